// File: rtl/param_frame_serializer.sv
// param_frame_serializer: buffers up to NUM_CHANNELS samples received over a
// valid/ready handshake, then emits HEADER, sample count, samples, footer.
// A partial buffer is flushed after TIMEOUT idle cycles (0 = never).
// Optional build macro PARAM_FRAME_SERIALIZER_CHECKSUM_EN inserts an XOR
// checksum word between the last sample and the footer.
module param_frame_serializer #(
    parameter int unsigned       DATA_W       = 8,
    parameter int unsigned       NUM_CHANNELS = 16,
    parameter int unsigned       TIMEOUT      = 8,
    parameter logic [DATA_W-1:0] HEADER       = 'hA5,
    parameter logic [DATA_W-1:0] FOOTER       = 'h5A
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_sof,
    output logic              dout_eof
);

    localparam int unsigned IDX_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int unsigned CNT_W = $clog2(NUM_CHANNELS + 1);
    localparam int unsigned TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // The sample count must fit in one output word.
    generate
        if (NUM_CHANNELS < 1 ||
            longint'(NUM_CHANNELS) > (longint'(1) << DATA_W) - 1) begin : g_bad_cfg
            $error("param_frame_serializer: NUM_CHANNELS must be 1..2^DATA_W-1");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        COLLECT,
        HDR,
        CNT,
        DATA,
`ifdef PARAM_FRAME_SERIALIZER_CHECKSUM_EN
        CSUM,
`endif
        FTR
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] sample_buf_q [NUM_CHANNELS];
    logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [IDX_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [TMO_W-1:0]  idle_q, idle_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              dout_valid_q, dout_valid_d;
    logic              dout_sof_q, dout_sof_d;
    logic              dout_eof_q, dout_eof_d;
`ifdef PARAM_FRAME_SERIALIZER_CHECKSUM_EN
    logic [DATA_W-1:0] csum_q, csum_d;
`endif

    logic accept;
    logic last_rd;
    logic timed_out;

    assign din_ready  = (state_q == IDLE || state_q == COLLECT) && !rst;
    assign accept     = din_valid && din_ready;
    assign last_rd    = (CNT_W'(rd_ptr_q) == wr_ptr_q - CNT_W'(1));
    assign timed_out  = (TIMEOUT != 0) && (idle_q == TMO_W'(TIMEOUT - 1));

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_sof   = dout_sof_q;
    assign dout_eof   = dout_eof_q;

    // Sample buffer write port.
    // NOTE: the buffer has no reset; wr_ptr guards every read, so stale slots are never emitted.
    always_ff @(posedge clk) begin
        if (accept) begin
            sample_buf_q[wr_ptr_q[IDX_W-1:0]] <= din;
        end
    end

    // Next-state and next-output logic for collection and frame emission.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        idle_d       = idle_q;
        dout_d       = '0;
        dout_valid_d = 1'b0;
        dout_sof_d   = 1'b0;
        dout_eof_d   = 1'b0;
`ifdef PARAM_FRAME_SERIALIZER_CHECKSUM_EN
        csum_d       = csum_q;
`endif

        case (state_q)
            IDLE, COLLECT: begin
                if (accept) begin
                    // An accept always wins over an expiring idle counter.
                    wr_ptr_d = wr_ptr_q + CNT_W'(1);
                    idle_d   = '0;
                    state_d  = (wr_ptr_q == CNT_W'(NUM_CHANNELS - 1)) ? HDR : COLLECT;
`ifdef PARAM_FRAME_SERIALIZER_CHECKSUM_EN
                    csum_d   = csum_q ^ din;
`endif
                end else if (state_q == COLLECT) begin
                    if (timed_out) begin
                        idle_d  = '0;
                        state_d = HDR;
                    end else if (TIMEOUT != 0) begin
                        idle_d = idle_q + TMO_W'(1);
                    end
                end
            end
            HDR: begin
                dout_d       = HEADER;
                dout_valid_d = 1'b1;
                dout_sof_d   = 1'b1;
                rd_ptr_d     = '0;
                state_d      = CNT;
            end
            CNT: begin
                dout_d       = DATA_W'(wr_ptr_q);
                dout_valid_d = 1'b1;
                state_d      = DATA;
            end
            DATA: begin
                dout_d       = sample_buf_q[rd_ptr_q];
                dout_valid_d = 1'b1;
                rd_ptr_d     = rd_ptr_q + IDX_W'(1);
                if (last_rd) begin
`ifdef PARAM_FRAME_SERIALIZER_CHECKSUM_EN
                    state_d = CSUM;
`else
                    state_d = FTR;
`endif
                end
            end
`ifdef PARAM_FRAME_SERIALIZER_CHECKSUM_EN
            CSUM: begin
                dout_d       = csum_q;
                dout_valid_d = 1'b1;
                state_d      = FTR;
            end
`endif
            FTR: begin
                dout_d       = FOOTER;
                dout_valid_d = 1'b1;
                dout_eof_d   = 1'b1;
                wr_ptr_d     = '0;
                rd_ptr_d     = '0;
                state_d      = IDLE;
`ifdef PARAM_FRAME_SERIALIZER_CHECKSUM_EN
                csum_d       = '0;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pointer and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so all registers update from pre-edge values.
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            idle_q       <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            dout_sof_q   <= 1'b0;
            dout_eof_q   <= 1'b0;
`ifdef PARAM_FRAME_SERIALIZER_CHECKSUM_EN
            csum_q       <= '0;
`endif
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            idle_q       <= idle_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            dout_sof_q   <= dout_sof_d;
            dout_eof_q   <= dout_eof_d;
`ifdef PARAM_FRAME_SERIALIZER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_param_frame_serializer.sv
// Directed bench for param_frame_serializer (default parameters).
// Expected frames include the checksum word when the design is built with
// PARAM_FRAME_SERIALIZER_CHECKSUM_EN.
module tb_param_frame_serializer;

    localparam int TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       din_valid;
    logic       din_ready;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_sof;
    logic       dout_eof;

    int tests = 0;
    int fails = 0;

    logic [7:0] samples [$];
    logic [7:0] frame   [$];
    int         seen;

    param_frame_serializer #(
        .DATA_W       (8),
        .NUM_CHANNELS (16),
        .TIMEOUT      (TIMEOUT),
        .HEADER       (8'hA5),
        .FOOTER       (8'h5A)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_sof   (dout_sof),
        .dout_eof   (dout_eof)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d);
        chk("send_ready", din_ready, 1);
        din       = d;
        din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
    endtask

    // Called right after the last accept; leaves the header on dout.
    task automatic await_flush();
        repeat (TIMEOUT) tick();
        chk("flush_pending_ready", din_ready, 0);
        chk("flush_pending_valid", dout_valid, 0);
        tick();
    endtask

    task automatic make_frame(input logic [7:0] s [$], output logic [7:0] f [$]);
`ifdef PARAM_FRAME_SERIALIZER_CHECKSUM_EN
        logic [7:0] x;
        x = 8'h00;
`endif
        f = {};
        f.push_back(8'hA5);
        f.push_back(8'(s.size()));
        foreach (s[i]) begin
            f.push_back(s[i]);
`ifdef PARAM_FRAME_SERIALIZER_CHECKSUM_EN
            x = x ^ s[i];
`endif
        end
`ifdef PARAM_FRAME_SERIALIZER_CHECKSUM_EN
        f.push_back(x);
`endif
        f.push_back(8'h5A);
    endtask

    // Checks one word per cycle starting with the header already on dout.
    task automatic check_frame(input string name, input logic [7:0] f [$]);
        int last;
        last = f.size() - 1;
        for (int i = 0; i <= last; i++) begin
            chk($sformatf("%s_word%0d", name, i), dout, f[i]);
            chk($sformatf("%s_valid%0d", name, i), dout_valid, 1);
            chk($sformatf("%s_sof%0d", name, i), dout_sof, (i == 0) ? 1 : 0);
            chk($sformatf("%s_eof%0d", name, i), dout_eof, (i == last) ? 1 : 0);
            chk($sformatf("%s_ready%0d", name, i), din_ready, (i == last) ? 1 : 0);
            tick();
        end
        chk({name, "_after_valid"}, dout_valid, 0);
        chk({name, "_after_dout"}, dout, 0);
        chk({name, "_after_ready"}, din_ready, 1);
    endtask

    initial begin
        rst       = 1'b1;
        din       = 8'h00;
        din_valid = 1'b0;
        tick();
        tick();
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_sof", dout_sof, 0);
        chk("rst_eof", dout_eof, 0);
        chk("rst_ready", din_ready, 0);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", din_ready, 1);

        // Partial frame flushed by the idle timeout.
        samples = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};
        foreach (samples[i]) send(samples[i]);
        await_flush();
        make_frame(samples, frame);
        check_frame("partial", frame);

        // Full buffer; 77 is held valid through the flush.
        samples = {};
        for (int i = 0; i < 16; i++) samples.push_back(8'(i));
        foreach (samples[i]) send(samples[i]);
        din       = 8'h77;
        din_valid = 1'b1;
        chk("full_hdr_ready", din_ready, 0);
        chk("full_hdr_valid", dout_valid, 0);
        tick();
        make_frame(samples, frame);
        check_frame("full", frame);
        din_valid = 1'b0;
        await_flush();
        samples = '{8'h77};
        make_frame(samples, frame);
        check_frame("held", frame);

        // A 7-cycle gap keeps the frame open; an 8-cycle gap flushes it.
        send(8'h31);
        repeat (7) tick();
        chk("gap7_ready", din_ready, 1);
        chk("gap7_valid", dout_valid, 0);
        send(8'h32);
        await_flush();
        samples = '{8'h31, 8'h32};
        make_frame(samples, frame);
        check_frame("gap", frame);

        // Reset during DATA aborts the frame without a footer.
        samples = '{8'h41, 8'h42, 8'h43};
        foreach (samples[i]) send(samples[i]);
        await_flush();
        chk("abort_hdr", dout, 8'hA5);
        tick();
        chk("abort_cnt", dout, 8'h03);
        tick();
        chk("abort_data0", dout, 8'h41);
        rst = 1'b1;
        #1;
        chk("abort_rst_ready", din_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("abort_dout", dout, 0);
        chk("abort_valid", dout_valid, 0);
        chk("abort_sof", dout_sof, 0);
        chk("abort_eof", dout_eof, 0);
        chk("abort_ready", din_ready, 1);
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (dout_valid) seen++;
        end
        chk("abort_no_words", seen, 0);
        samples = '{8'h51, 8'h52};
        foreach (samples[i]) send(samples[i]);
        await_flush();
        make_frame(samples, frame);
        check_frame("after_abort", frame);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/param_frame_serializer.md
Name: param_frame_serializer

Overview:
- Parametrised successor to the fixed 8-bit/16-channel serializer.
- Collects DATA_W-bit channel samples over a valid/ready handshake into an internal buffer of NUM_CHANNELS entries.
- Emits one framed stream per buffer: HEADER, sample count, samples, footer.
- Flushes on a full buffer, or early on an idle timeout, so partial frames always get a footer. Sits between channel front-end and link/packet layer.

Parameters:
- DATA_W, 8, width of samples and of every output word.
- NUM_CHANNELS, 16, buffer depth and maximum samples per frame. Elaboration error if NUM_CHANNELS > 2^DATA_W-1.
- TIMEOUT, 8, idle cycles after the last accept before a partial flush. 0 disables the timeout, so only a full buffer flushes.
- HEADER, 'hA5, header word (DATA_W bits).
- FOOTER, 'h5A, footer word (DATA_W bits).

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- din  in  DATA_W  sample data
- din_valid  in  1  sample present
- din_ready  out  1  block can accept; a sample transfers when din_valid && din_ready at a clk edge
- dout  out  DATA_W  serial frame word; 0 when dout_valid=0
- dout_valid  out  1  dout carries a frame word
- dout_sof  out  1  high with the header word only
- dout_eof  out  1  high with the footer word only

Behaviour:
- Clock and reset: one clock (clk). rst is synchronous and active-high.
- Reset values: dout=0, dout_valid=0, dout_sof=0, dout_eof=0. State IDLE; write pointer, idle counter and checksum cleared.
- din_ready: combinational = (state is IDLE or COLLECT) && !rst. It is 0 while rst is high.
- All dout* outputs are registered.
- States: IDLE → COLLECT → HDR → CNT → DATA → [CSUM] → FTR → IDLE.
- IDLE: no samples buffered.
  - An accept writes buf[0] and moves to COLLECT (wr_ptr=1).
- COLLECT: each accept writes buf[wr_ptr] and increments wr_ptr.
  - The idle counter clears on an accept and increments on every cycle without one.
  - Accept with wr_ptr = NUM_CHANNELS-1 (buffer full) → HDR.
  - TIMEOUT≠0 and idle counter reaches TIMEOUT-1 with no accept → HDR. If the last accept is at edge k, the header is on dout after edge k+TIMEOUT+1.
  - An accept in the same cycle the counter would expire wins: the sample is stored and the counter clears.
- Full-buffer timing: Nth sample accepted at edge k →
  - header after edge k+1;
  - count word at k+2;
  - samples buf[0..n-1] at k+3..k+2+n, oldest first;
  - footer at k+3+n (k+4+n when CSUM is present).
- dout_valid is continuous for the whole frame, with no bubbles.
- Count word: n = number of samples buffered (1..NUM_CHANNELS), zero-extended to DATA_W.
- Unfilled buffer slots are never emitted.
- Flush (HDR..FTR): din_ready=0; din_valid is ignored and no sample is lost or duplicated.
  - The cycle after the footer: state IDLE, din_ready=1, wr_ptr=0.
- Reset mid-frame: the frame is aborted and the buffer discarded; no footer is emitted. Outputs read 0 in the cycle after the reset edge.
- There is no back-pressure on dout; the downstream consumer must accept one word per cycle.

Optional Feature:
- Macro: PARAM_FRAME_SERIALIZER_CHECKSUM_EN.
- Defined:
  - A running XOR of all accepted samples in the frame is held in a register.
  - State CSUM emits it between the last sample and the footer; the frame is n+4 words.
  - The register clears on reset and when the footer is emitted.
- Undefined: no CSUM state and no checksum register; the frame is n+3 words.

Test Plan:
- Default params. Accept A1,B2,C3,D4 on consecutive cycles, then din_valid=0 → after 8 idle cycles, dout = A5(sof),04,A1,B2,C3,D4,5A(eof) on 7 consecutive cycles, then dout_valid=0 and din_ready=1.
- 16 samples 00..0F back-to-back → A5,10,00..0F,5A. din_ready is low from the cycle after sample 0F through the footer cycle (19 cycles).
- Hold din_valid=1 with din=77 during a flush → 77 is not accepted during the flush. 77 is the first sample of the next frame, accepted on the first din_ready=1 cycle.
- Timeout boundary: samples separated by 7 idle cycles → no flush, and they land in the same frame. An 8-cycle gap → flush, and the count word equals the samples before the gap.
- Assert rst for one cycle during DATA → outputs zero next cycle, no 5A emitted. The next 2-sample frame emits A5,02,...,5A.
- With PARAM_FRAME_SERIALIZER_CHECKSUM_EN: samples A1,B2,C3,D4 with timeout → A5,04,A1,B2,C3,D4,04,5A (checksum 04 = A1^B2^C3^D4).
